// File: rtl/fifo_flops_mc_pkg.sv
// -----------------------------------------------------------------------------
// fifo_flops_mc_pkg
// Shared helpers for the multi-channel flop FIFO:
//   ptr_w   - read/write pointer width for a queue of a given depth
//   cnt_w   - occupancy counter width (must also hold the value 'depth')
//   chan_w  - width of a channel index, used to build the channel-index type
//   rr_scan - round-robin arbiter scan: the first set bit of a non-empty mask,
//             searching rr, rr+1, ... modulo the channel count
// -----------------------------------------------------------------------------
package fifo_flops_mc_pkg;

  // Upper bound on the channel count the arbiter scan supports.
  localparam int MAX_CH = 32;

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns the index of the first non-empty channel at or after rr (with
  // wrap-around). With an all-zero mask the result is rr itself; callers
  // qualify the result with the OR of the mask.
  function automatic int rr_scan(input int rr, input logic [MAX_CH-1:0] mask,
                                 input int n);
    int res;
    int s;
    res = rr;
    // Walk from the farthest candidate back to rr so the nearest hit wins.
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        s = rr + k;
        if (s >= n) s = s - n;
        if (mask[s[4:0]]) res = s;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_mc_chan.sv
// -----------------------------------------------------------------------------
// fifo_mc_chan
// One flop-based circular queue. The parent decides which writes and reads
// are accepted; this block simply performs them.
//
// Ports
//   clk    clock, rising edge
//   rst    synchronous reset, active low; clears pointers and count
//   wr_en  accepted write: store din at the write pointer
//   rd_en  accepted read: drop the head entry
//   din    write data
//   head   entry at the read pointer (first-word fall-through)
//   count  current occupancy, 0..depth
//   full   count == depth
//   empty  count == 0
// -----------------------------------------------------------------------------
module fifo_mc_chan
  import fifo_flops_mc_pkg::*;
#(
  parameter int bits  = 16,
  parameter int depth = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [bits-1:0]         din,
  output logic [bits-1:0]         head,
  output logic [cnt_w(depth)-1:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW   = ptr_w(depth);
  localparam int CNTW = cnt_w(depth);

  logic [bits-1:0] mem [depth];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      // depth is a power of two, so the pointers wrap naturally.
      if (wr_en) wptr <= wptr + PW'(1);
      if (rd_en) rptr <= rptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; after reset the count is zero, so
  // stale words are never visible, and leaving it out keeps these plain flops.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wptr] <= din;
  end

  // On a full queue with a same-cycle read, wptr == rptr: the head is read
  // before the edge and the slot is overwritten at the edge, which is fine.
  assign head  = mem[rptr];
  assign full  = (count == CNTW'(depth));
  assign empty = (count == '0);

endmodule

// File: rtl/fifo_flops_mc.sv
// -----------------------------------------------------------------------------
// fifo_flops_mc
// CHANNELS independent flop queues, one producer each, drained through a
// single output port by a round-robin arbiter. The output word carries its
// channel index. Sticky error flags report pushes into full queues and pops
// with nothing pending.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   push       per-channel write strobe            [CHANNELS]
//   Din        per-channel data, channel c at [c*bits +: bits]
//   full       per-channel queue full              [CHANNELS]
//   pop        consumer read strobe
//   Dout       head word of the granted channel (0 when nothing pending)
//   Dout_ch    channel index of Dout (0 when nothing pending)
//   pndng      at least one channel is non-empty
//   overflow   sticky, push seen on a full channel  [CHANNELS]
//   underflow  sticky, pop seen while pndng = 0
//   afull      per-channel count >= AFULL_TH (only with FIFO_FLOPS_MC_AFULL_EN)
//
// Build option: define FIFO_FLOPS_MC_AFULL_EN to add parameter AFULL_TH and
// the afull output.
// -----------------------------------------------------------------------------
module fifo_flops_mc
  import fifo_flops_mc_pkg::*;
#(
  parameter int bits     = 16,
  parameter int depth    = 8,
  parameter int CHANNELS = 4
`ifdef FIFO_FLOPS_MC_AFULL_EN
  ,
  parameter int AFULL_TH = depth - 2
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         push,
  input  logic [CHANNELS*bits-1:0]    Din,
  output logic [CHANNELS-1:0]         full,
  input  logic                        pop,
  output logic [bits-1:0]             Dout,
  output logic [$clog2(CHANNELS)-1:0] Dout_ch,
  output logic                        pndng,
  output logic [CHANNELS-1:0]         overflow,
  output logic                        underflow
`ifdef FIFO_FLOPS_MC_AFULL_EN
  ,
  output logic [CHANNELS-1:0]         afull
`endif
);

  localparam int CW   = chan_w(CHANNELS);
  localparam int CNTW = cnt_w(depth);

  typedef logic [CW-1:0] chan_t;

  logic [bits-1:0]     head  [CHANNELS];
  logic [CNTW-1:0]     count [CHANNELS];
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] nonempty;
  logic [CHANNELS-1:0] wr_en;
  logic [CHANNELS-1:0] rd_en;
  logic [CHANNELS-1:0] ovf_set;
  chan_t               rr_ptr;
  chan_t               grant;
  logic                pop_ok;

  // ---------------------------------------------------------------------------
  // Per-channel queues
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    fifo_mc_chan #(
      .bits  (bits),
      .depth (depth)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en[c]),
      .rd_en (rd_en[c]),
      .din   (Din[c*bits +: bits]),
      .head  (head[c]),
      .count (count[c]),
      .full  (full[c]),
      .empty (empty[c])
    );

`ifdef FIFO_FLOPS_MC_AFULL_EN
    assign afull[c] = (count[c] >= CNTW'(AFULL_TH));
`else
    logic [CNTW-1:0] count_unused;
    assign count_unused = count[c];
`endif
  end

  // ---------------------------------------------------------------------------
  // Arbiter: purely a function of registered state
  // ---------------------------------------------------------------------------
  assign nonempty = ~empty;
  assign pndng    = |nonempty;
  assign grant    = chan_t'(rr_scan(int'(rr_ptr), MAX_CH'(nonempty), CHANNELS));
  assign pop_ok   = pop && pndng;
  assign Dout     = pndng ? head[grant] : '0;
  assign Dout_ch  = pndng ? grant : '0;

  // Accept/reject per channel. A push into a full queue is still accepted when
  // that same queue is being popped, since a slot frees up at the same edge.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    rd_en   = '0;
    wr_en   = '0;
    ovf_set = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rd_en[c]   = pop_ok && (grant == chan_t'(c));
      wr_en[c]   = push[c] && (!full[c] || rd_en[c]);
      ovf_set[c] = push[c] && full[c] && !rd_en[c];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pointer and sticky error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr    <= '0;
      overflow  <= '0;
      underflow <= 1'b0;
    end else begin
      // The channel after the one just served gets first look next cycle.
      if (pop_ok) begin
        if (grant == chan_t'(CHANNELS - 1)) rr_ptr <= '0;
        else                                rr_ptr <= grant + chan_t'(1);
      end
      overflow <= overflow | ovf_set;
      if (pop && !pndng) underflow <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_flops_mc.md
Name: fifo_flops_mc

Overview:
- Multi-channel successor to the single-queue flop FIFO: CHANNELS independent flop-based queues, each written by its own producer.
- Queues drain through one shared output port under a round-robin arbiter.
- Adds per-channel full flags, sticky overflow/underflow error flags, and a channel tag on the output word.
- Sits between several producer agents and a single consumer in the same clk domain.

Parameters:
- bits, 16, data word width.
- depth, 8, entries per channel; must be a power of two, ≥2.
- CHANNELS, 4, number of input queues; ≥2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low (0 = reset).
- push  input  CHANNELS  per-channel write strobe.
- Din  input  CHANNELS*bits  per-channel write data; channel c occupies bits [c*bits +: bits].
- full  output  CHANNELS  per-channel queue full.
- pop  input  1  consumer read strobe.
- Dout  output  bits  head word of the granted channel (first-word fall-through).
- Dout_ch  output  $clog2(CHANNELS)  channel index of Dout.
- pndng  output  1  at least one channel non-empty; Dout/Dout_ch valid.
- overflow  output  CHANNELS  sticky: push seen on a full channel.
- underflow  output  1  sticky: pop seen while pndng=0.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All channel counts and read/write pointers go to 0; rr_ptr goes to 0.
  - full=0, pndng=0, Dout=0, Dout_ch=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all queued data in that cycle; push/pop in the same cycle are ignored.
- Per-channel queue: circular buffer with wptr, rptr and count (width $clog2(depth)+1). Pointers wrap depth-1 → 0.
- full[c] = (count[c] == depth), registered-state derived, no combinational path from push.
- Arbiter (combinational from state):
  - grant = first non-empty channel scanning rr_ptr, rr_ptr+1, … mod CHANNELS.
  - pndng = OR of non-empty channels.
  - Dout = head of grant; Dout_ch = grant.
  - When pndng=0: Dout=0, Dout_ch=0.
- Pop (pop=1 and pndng=1):
  - Remove the head of grant.
  - Next cycle rr_ptr = (grant+1) mod CHANNELS.
  - Zero-cycle latency: the word popped is the word visible in that cycle.
- Pop with pndng=0: no state change except underflow←1.
- Push on channel c with full[c]=0: write Din[c] at wptr[c], count+1. The data is visible on Dout no earlier than the next cycle.
- Push on full channel c:
  - If the same cycle pops grant==c, the push is accepted and count stays depth.
  - Otherwise the word is dropped, overflow[c]←1, state unchanged.
- Simultaneous push and pop on the same non-full channel: count unchanged, both pointers advance.
- Pushes on multiple channels in one cycle are all accepted independently.
- rr_ptr is unchanged in cycles without a successful pop.
- Fairness: with all channels continuously non-empty and pop held high, grants cycle 0,1,2,3,0,…

Optional Feature:
- Macro: FIFO_FLOPS_MC_AFULL_EN.
- When defined:
  - Adds parameter AFULL_TH (default depth-2).
  - Adds output afull [CHANNELS]: afull[c]=(count[c] ≥ AFULL_TH). Reset value 0.
- When undefined: the port and parameter do not exist. Behaviour is otherwise identical.

Decomposition:
- Package fifo_flops_mc_pkg holds:
  - the count/pointer width functions;
  - the channel-index typedef helper;
  - the arbiter scan function (next non-empty index from rr_ptr and a non-empty mask).
- Natural sub-module: fifo_mc_chan, one single-channel queue with inputs wr_en/rd_en and outputs head/count/full/empty, instantiated CHANNELS times in a generate loop.
- Arbiter, rr_ptr and error flags live in the top.

Test Plan (bits=16, depth=8, CHANNELS=4):
- Reset: drive rst=0 for 2 cycles after random pushes → full=4'b0000, pndng=0, Dout=0, overflow=0, underflow=0.
- Single channel order: push 0x1111, 0x2222, 0x3333 on ch2 → Dout_ch=2 and Dout=0x1111, 0x2222, 0x3333 on successive pops; then pndng=0.
- Round-robin: preload ch0=0xA0, ch1=0xB1, ch3=0xD3, hold pop=1 → outputs (0,0xA0), (1,0xB1), (3,0xD3); ch2 skipped; pndng=0 after the third pop.
- Full/overflow: push 9 words 0x0000..0x0008 on ch1 → full[1]=1 after the 8th; 9th dropped, overflow[1]=1 sticky; pops return 0x0000..0x0007.
- Full with simultaneous pop: ch0 full and the only non-empty channel; push 0xBEEF with pop=1 → accepted, full[0] stays 1, 0xBEEF is popped 8th.
- Underflow/reset mid-op: pop with all channels empty → underflow=1, no other change. Push 0x5555 on ch3 with rst=0 in the same cycle → after reset pndng=0 and underflow=0.
